// File: rtl/dmem_responder.sv
// Data-memory responder: valid/ready request, fixed-latency response, word-addressed storage.
// Optional DMEM_ADDR_CHECK_EN flags misaligned or out-of-range addresses with rsp_err.
module dmem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);
    localparam int AW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t         state, state_nxt;
    logic [3:0]     cnt;
    logic           lat_we;
    logic [AW-1:0]  lat_idx;
    logic [31:0]    lat_wdata;
    logic [3:0]     lat_be;
    logic           lat_err;
    logic [31:0]    mem [DEPTH_WORDS];
    logic           accept, access, rsp_done, addr_err;
    logic [AW-1:0]  req_idx;

    assign req_idx = req_addr[AW+1:2];

`ifdef DMEM_ADDR_CHECK_EN
    assign addr_err = (req_addr[1:0] != 2'b00) ||
                      ({2'b00, req_addr[31:2]} >= 32'(DEPTH_WORDS));
`else
    logic unused_addr;
    assign addr_err    = 1'b0;
    assign unused_addr = ^{req_addr[31:AW+2], req_addr[1:0]};
`endif

    // Every accepted request passes through WAIT; the counter starts at
    // LATENCY-1 so RESP is entered exactly LATENCY edges after the accept.
    always_comb begin
        state_nxt = state;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        accept    = 1'b0;
        access    = 1'b0;
        rsp_done  = 1'b0;
        case (state)
            IDLE: begin
                req_ready = reset;
                if (req_valid && reset) begin
                    accept    = 1'b1;
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (cnt == 4'd0) begin
                    access    = reset;
                    state_nxt = RESP;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    rsp_done  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt       <= 4'd0;
            rsp_rdata <= 32'd0;
            rsp_err   <= 1'b0;
            lat_we    <= 1'b0;
            lat_idx   <= '0;
            lat_wdata <= 32'd0;
            lat_be    <= 4'd0;
            lat_err   <= 1'b0;
        end else begin
            if (accept) begin
                lat_we    <= req_we;
                lat_idx   <= req_idx;
                lat_wdata <= req_wdata;
                lat_be    <= req_be;
                lat_err   <= addr_err;
                cnt       <= 4'(LATENCY - 1);
            end else if (state == WAIT && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
            if (access) begin
                rsp_err   <= lat_err;
                rsp_rdata <= (lat_we || lat_err) ? 32'd0 : mem[lat_idx];
            end else if (rsp_done) begin
                rsp_err   <= 1'b0;
                rsp_rdata <= 32'd0;
            end
        end
    end

    // Storage is not reset; a store dropped by reset never reaches this edge.
    always_ff @(posedge clk) begin
        if (access && lat_we && !lat_err) begin
            for (int b = 0; b < 4; b++) begin
                if (lat_be[b]) mem[lat_idx][8*b +: 8] <= lat_wdata[8*b +: 8];
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: instance 0 (LATENCY=2) tracked by a timestamp model,
// instance 1 (LATENCY=3) used for the mid-operation reset case.
module tb_dmem_responder;
    localparam int DEPTH = 256;

    logic        clk = 1'b0;
    logic        rst       [2];
    logic        req_valid [2];
    logic        req_ready [2];
    logic        req_we    [2];
    logic [31:0] req_addr  [2];
    logic [31:0] req_wdata [2];
    logic [3:0]  req_be    [2];
    logic        rsp_valid [2];
    logic        rsp_ready [2];
    logic [31:0] rsp_rdata [2];
    logic        rsp_err   [2];

    int total = 0;
    int bad   = 0;
    bit chk_on = 0;

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(2)) u_dut0 (
        .clk(clk), .reset(rst[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_we(req_we[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_be(req_be[0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
    );

    dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(3)) u_dut1 (
        .clk(clk), .reset(rst[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_we(req_we[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_be(req_be[1]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic int widx(input logic [31:0] a);
        return int'((a >> 2) % DEPTH);
    endfunction

    function automatic bit aerr(input logic [31:0] a);
`ifdef DMEM_ADDR_CHECK_EN
        return (a[1:0] != 2'b00) || ((a >> 2) >= DEPTH);
`else
        return (a === 32'hxxxx_xxxx);
`endif
    endfunction

    // Model of instance 0: response due LATENCY edges after the accept edge.
    int          ncyc = 0;
    int          m_due = 0;
    bit          m_busy = 0, m_valid = 0, m_known = 1, m_err = 0;
    logic [31:0] m_rdata = 0;
    bit          q_we;
    logic [31:0] q_addr, q_wdata;
    logic [3:0]  q_be;
    logic [31:0] m_mem [int];

    always @(posedge clk) begin
        logic [31:0] w;
        int i;
        ncyc++;
        if (!rst[0]) begin
            m_busy = 0; m_valid = 0;
        end else if (m_valid) begin
            if (rsp_ready[0]) begin m_valid = 0; m_busy = 0; end
        end else if (m_busy) begin
            if (ncyc == m_due) begin
                i = widx(q_addr);
                m_valid = 1; m_err = aerr(q_addr); m_rdata = 0; m_known = 1;
                if (!m_err) begin
                    w = m_mem.exists(i) ? m_mem[i] : 32'hxxxx_xxxx;
                    if (q_we) begin
                        for (int b = 0; b < 4; b++) if (q_be[b]) w[8*b +: 8] = q_wdata[8*b +: 8];
                        m_mem[i] = w;
                    end else begin
                        m_rdata = w;
                        m_known = !$isunknown(w);
                    end
                end
            end
        end else if (req_valid[0]) begin
            m_busy = 1; m_due = ncyc + 2;
            q_we = req_we[0]; q_addr = req_addr[0]; q_wdata = req_wdata[0]; q_be = req_be[0];
        end
    end

    always begin
        @(negedge clk);
        #1;
        if (chk_on) begin
            chk("cyc_req_ready", req_ready[0], rst[0] && !m_busy);
            chk("cyc_rsp_valid", rsp_valid[0], m_valid);
            if (!m_valid || m_known) chk("cyc_rsp_rdata", rsp_rdata[0], m_valid ? m_rdata : 32'd0);
            chk("cyc_rsp_err", rsp_err[0], m_valid ? m_err : 1'b0);
        end
    end

    task automatic txn(input int d, input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] be, input int stall,
                       output logic [31:0] rd, output bit er, output int lat);
        int n;
        logic [31:0] first;
        @(negedge clk);
        req_valid[d] = 1; req_we[d] = we; req_addr[d] = addr; req_wdata[d] = wdata;
        req_be[d] = be; rsp_ready[d] = 0;
        #1;
        n = 0;
        while (!req_ready[d] && n < 20) begin @(negedge clk); #1; n++; end
        if (n >= 20) chk("accept_timeout", req_ready[d], 1);
        @(posedge clk);
        @(negedge clk);
        req_valid[d] = 0;
        #1;
        lat = 0;
        while (!rsp_valid[d] && lat < 40) begin @(negedge clk); #1; lat++; end
        if (lat >= 40) chk("rsp_timeout", rsp_valid[d], 1);
        first = rsp_rdata[d];
        for (int s = 0; s < stall; s++) begin
            @(negedge clk); #1;
            chk("stall_valid", rsp_valid[d], 1);
            chk("stall_rdata", rsp_rdata[d], first);
            chk("stall_req_ready", req_ready[d], 0);
        end
        rd = rsp_rdata[d];
        er = rsp_err[d];
        rsp_ready[d] = 1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready[d] = 0;
        #1;
        chk("rsp_drop", rsp_valid[d], 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd;
        bit er;
        int lat;
        for (int d = 0; d < 2; d++) begin
            rst[d] = 0; req_valid[d] = 0; req_we[d] = 0; req_addr[d] = 0;
            req_wdata[d] = 0; req_be[d] = 0; rsp_ready[d] = 0;
        end
        repeat (3) @(posedge clk);
        chk_on = 1;
        @(negedge clk);
        rst[0] = 1; rst[1] = 1;
        @(posedge clk);
        @(negedge clk); #1;
        chk("rst_req_ready", req_ready[0], 1);
        chk("rst_rsp_valid", rsp_valid[0], 0);
        chk("rst_rsp_rdata", rsp_rdata[0], 0);
        chk("rst_req_ready_b", req_ready[1], 1);

        txn(0, 1, 32'h10, 32'hDEAD_BEEF, 4'hF, 0, rd, er, lat);
        chk("store_lat", lat, 2);
        chk("store_rdata", rd, 0);
        txn(0, 0, 32'h10, 32'h0, 4'h0, 0, rd, er, lat);
        chk("load_lat", lat, 2);
        chk("load_rdata", rd, 32'hDEAD_BEEF);

        txn(0, 1, 32'h10, 32'h0000_0055, 4'b0001, 0, rd, er, lat);
        txn(0, 0, 32'h10, 32'h0, 4'h0, 0, rd, er, lat);
        chk("byte_merge", rd, 32'hDEAD_BE55);

        txn(0, 1, 32'h10, 32'hFFFF_FFFF, 4'b0000, 0, rd, er, lat);
        chk("be0_rdata", rd, 0);
        txn(0, 0, 32'h10, 32'h0, 4'h0, 5, rd, er, lat);
        chk("stall_load", rd, 32'hDEAD_BE55);

        txn(0, 1, 32'h0, 32'hA5A5_A5A5, 4'hF, 0, rd, er, lat);
        txn(0, 0, 32'h402, 32'h0, 4'h0, 0, rd, er, lat);
`ifdef DMEM_ADDR_CHECK_EN
        chk("misalign_err", er, 1);
        chk("misalign_rdata", rd, 0);
`else
        chk("wrap_err", er, 0);
        chk("wrap_rdata", rd, 32'hA5A5_A5A5);
`endif
        txn(0, 1, 32'h400, 32'h1234_5678, 4'hF, 0, rd, er, lat);
`ifdef DMEM_ADDR_CHECK_EN
        chk("oor_store_err", er, 1);
`else
        chk("wrap_store_err", er, 0);
`endif
        txn(0, 0, 32'h0, 32'h0, 4'h0, 0, rd, er, lat);
`ifdef DMEM_ADDR_CHECK_EN
        chk("word0_kept", rd, 32'hA5A5_A5A5);
`else
        chk("word0_wrapped", rd, 32'h1234_5678);
`endif

        // Mid-operation reset on the LATENCY=3 instance.
        txn(1, 1, 32'h20, 32'h1111_2222, 4'hF, 0, rd, er, lat);
        chk("b_store_lat", lat, 3);
        @(negedge clk);
        req_valid[1] = 1; req_we[1] = 1; req_addr[1] = 32'h20;
        req_wdata[1] = 32'hFFFF_FFFF; req_be[1] = 4'hF;
        #1;
        chk("b_accept_ready", req_ready[1], 1);
        @(posedge clk);
        @(negedge clk);
        req_valid[1] = 0; rst[1] = 0;
        #1;
        chk("b_ready_in_reset", req_ready[1], 0);
        @(negedge clk);
        @(negedge clk);
        rst[1] = 1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk); #1;
            chk("b_no_stale_rsp", rsp_valid[1], 0);
        end
        txn(1, 0, 32'h20, 32'h0, 4'h0, 0, rd, er, lat);
        chk("b_load_lat", lat, 3);
        chk("b_store_dropped", rd, 32'h1111_2222);

        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
